// File: rtl/spi_master_lite.sv
// Mode-0 SPI master that transfers one 1..16-bit frame per request (req_len 0 means 16 bits).
// Defining SPI_MASTER_LOOPBACK_EN makes the receiver sample the internal mosi instead of the miso port.
module spi_master_lite #(
   parameter int unsigned DIV = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_len,
   input  logic [15:0] req_data,
   output logic        rsp_valid,
   output logic [15:0] rsp_data,
   output logic        sck,
   output logic        ss,
   output logic        mosi,
   input  logic        miso
);

   if (DIV < 1 || DIV > 255) begin : g_div_check
      $error("spi_master_lite: DIV must be in 1..255");
   end

   typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, DONE} state_t;

   state_t      state, state_nxt;
   logic [7:0]  cnt;
   logic [4:0]  bit_cnt;
   logic [4:0]  bit_total;
   logic [15:0] tx;
   logic [15:0] rx;
   logic        armed;
   logic        accept;
   logic        cnt_end;
   logic        last_bit;
   logic        sample;

   assign accept   = req_valid && req_ready;
   assign cnt_end  = (cnt == 8'(DIV - 1));
   assign last_bit = (bit_cnt == bit_total);

`ifdef SPI_MASTER_LOOPBACK_EN
   logic unused_miso;
   assign unused_miso = miso;
   assign sample      = mosi;
`else
   assign sample      = miso;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)  state_nxt = SETUP;
         SETUP:   if (cnt_end) state_nxt = HIGH;
         HIGH:    if (cnt_end) state_nxt = LOW;
         LOW:     if (cnt_end) state_nxt = last_bit ? DONE : HIGH;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      sck       = 1'b0;
      ss        = 1'b1;
      mosi      = 1'b1;
      case (state)
         IDLE:       req_ready = armed;
         SETUP, LOW: begin
            ss   = 1'b0;
            mosi = tx[15];
         end
         HIGH: begin
            ss   = 1'b0;
            sck  = 1'b1;
            mosi = tx[15];
         end
         DONE:       rsp_valid = 1'b1;
         default:    ;
      endcase
   end

   // armed holds req_ready low until the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed     <= 1'b0;
         cnt       <= '0;
         bit_cnt   <= '0;
         bit_total <= '0;
         tx        <= '0;
         rx        <= '0;
         rsp_data  <= '0;
      end else begin
         armed <= 1'b1;
         if (state_nxt != state || state == IDLE || state == DONE) cnt <= '0;
         else                                                      cnt <= cnt + 8'd1;

         if (state == IDLE && accept) begin
            tx        <= req_data;
            rx        <= '0;
            bit_cnt   <= '0;
            bit_total <= (req_len == 4'd0) ? 5'd16 : {1'b0, req_len};
         end else if (state == HIGH && cnt_end) begin
            tx      <= {tx[14:0], 1'b0};
            rx      <= {rx[14:0], sample};
            bit_cnt <= bit_cnt + 5'd1;
         end

         if (state == LOW && cnt_end && last_bit) rsp_data <= rx;
      end
   end

endmodule

// File: tb/tb_spi_master_lite.sv
// Bench for spi_master_lite: three instances (DIV=1,2,3), each with a selectable loopback wire or an
// 8-bit shift-register slave preset to 0xFF while ss is high; results are compared with a bit-queue model.
module tb_spi_master_lite;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n;
   logic [2:0]       req_valid, req_ready, rsp_valid, sck, ss, mosi, miso, loop;
   logic [2:0][3:0]  req_len;
   logic [2:0][15:0] req_data, rsp_data;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : g_dut
      logic       cap   = 1'b1;
      logic [7:0] shreg = 8'hFF;
      logic       prev_rv = 1'b0;

      spi_master_lite #(.DIV(g + 1)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .req_valid (req_valid[g]),
         .req_ready (req_ready[g]),
         .req_len   (req_len[g]),
         .req_data  (req_data[g]),
         .rsp_valid (rsp_valid[g]),
         .rsp_data  (rsp_data[g]),
         .sck       (sck[g]),
         .ss        (ss[g]),
         .mosi      (mosi[g]),
         .miso      (miso[g])
      );

      // Slave: captures mosi on sck rise, shifts on sck fall, presets while deselected.
      always @(posedge sck[g]) cap <= mosi[g];
      always @(negedge sck[g] or posedge ss[g]) begin
         if (ss[g]) shreg <= 8'hFF;
         else       shreg <= {shreg[6:0], cap};
      end
      assign miso[g] = loop[g] ? mosi[g] : shreg[7];

      always @(negedge clk) begin
         if (ss[g]) begin
            check("sck_low_when_ss_high", sck[g], 1'b0);
            check("mosi_high_when_ss_high", mosi[g], 1'b1);
         end
         check("rsp_valid_single_pulse", rsp_valid[g] & prev_rv, 1'b0);
         prev_rv <= rsp_valid[g];
      end
   end

   // Bits are received in send order from a queue: the slave first returns its eight preset ones.
   function automatic logic [15:0] model(input logic [15:0] tx, input int n, input bit lp);
      bit q[$];
      logic [15:0] r = '0;
      if (!lp) repeat (8) q.push_back(1'b1);
      for (int i = 15; i >= 16 - n; i--) q.push_back(tx[i]);
      for (int i = 0; i < n; i++) r = {r[14:0], q.pop_front()};
      return r;
   endfunction

   task automatic start(input int k, input logic [3:0] len, input logic [15:0] data);
      int w = 0;
      @(negedge clk);
      req_len[k]   = len;
      req_data[k]  = data;
      req_valid[k] = 1'b1;
      while (!req_ready[k] && w < 50) begin
         @(negedge clk);
         w++;
      end
      check("accept_ready", req_ready[k], 1'b1);
   endtask

   task automatic wait_rsp(input int k, input bit hold, output int lat, output int highs,
                           output int rises, output bit ss_gap);
      logic prev = 1'b0;
      lat = 0; highs = 0; rises = 0; ss_gap = 1'b0;
      do begin
         @(negedge clk);
         lat++;
         if (!hold) req_valid[k] = 1'b0;
         if (sck[k]) highs++;
         if (sck[k] && !prev) rises++;
         prev = sck[k];
         if (ss[k] && !rsp_valid[k]) ss_gap = 1'b1;
      end while (!rsp_valid[k] && lat < 3000);
   endtask

   task automatic do_frame(input int k, input logic [3:0] len, input logic [15:0] data,
                           input bit lp, input string tag);
      int n, lat, highs, rises;
      bit ss_gap;
      logic [15:0] exp;
      n   = (len == 4'd0) ? 16 : int'(len);
      exp = model(data, n, lp);
      loop[k] = lp;
      start(k, len, data);
      wait_rsp(k, 1'b0, lat, highs, rises, ss_gap);
      check({tag, "_latency"}, lat, (2 * n + 1) * (k + 1) + 1);
      check({tag, "_rsp_data"}, rsp_data[k], exp);
      check({tag, "_sck_rises"}, rises, n);
      check({tag, "_sck_high_cycles"}, highs, n * (k + 1));
      check({tag, "_ss_low_throughout"}, ss_gap, 1'b0);
      repeat (3) @(negedge clk);
      check({tag, "_rsp_hold"}, rsp_data[k], exp);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, highs, rises, pulses, w;
      bit ss_gap;
      logic [15:0] da, db, d;

      rst_n = 1'b0; req_valid = '0; req_len = '0; req_data = '0; loop = '0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check("rst_ss", ss[k], 1'b1);
         check("rst_sck", sck[k], 1'b0);
         check("rst_mosi", mosi[k], 1'b1);
         check("rst_req_ready", req_ready[k], 1'b0);
         check("rst_rsp_valid", rsp_valid[k], 1'b0);
         check("rst_rsp_data", rsp_data[k], 16'h0);
      end
      rst_n = 1'b1;
      #1 check("ready_before_edge", req_ready[0], 1'b0);
      @(posedge clk);
      #1 check("ready_after_edge", req_ready, 3'b111);

      do_frame(0, 4'd8, 16'hA500, 1'b1, "loop_div1_len8");
      do_frame(1, 4'd0, 16'h3C00, 1'b0, "slave_div2_len16");
      do_frame(2, 4'd1, 16'h8000, 1'b1, "loop_div3_len1");

      // Back-to-back with req_valid held high.
      da = 16'(($urandom_range(0, 7) << 12) | 16'h8000);
      db = 16'(($urandom_range(0, 7) << 12));
      loop[0] = 1'b1;
      start(0, 4'd4, da);
      wait_rsp(0, 1'b1, lat, highs, rises, ss_gap);
      check("b2b_first_latency", lat, 10);
      check("b2b_first_data", rsp_data[0], model(da, 4, 1'b1));
      req_data[0] = db;
      @(negedge clk);
      check("b2b_second_accept", req_ready[0] & req_valid[0], 1'b1);
      check("b2b_ss_gap", ss[0], 1'b1);
      wait_rsp(0, 1'b0, lat, highs, rises, ss_gap);
      check("b2b_second_latency", lat, 10);
      check("b2b_second_data", rsp_data[0], model(db, 4, 1'b1));

      // Reset at the 5th sck rise of a 16-bit frame.
      loop[1] = 1'b0;
      d = 16'($urandom);
      start(1, 4'd0, d);
      rises = 0; w = 0;
      begin
         logic prev = 1'b0;
         while (rises < 5 && w < 200) begin
            @(negedge clk);
            w++;
            req_valid[1] = 1'b0;
            if (sck[1] && !prev) rises++;
            prev = sck[1];
         end
      end
      check("midreset_reached_5th_rise", rises, 5);
      rst_n = 1'b0;
      #1;
      check("midreset_ss", ss[1], 1'b1);
      check("midreset_sck", sck[1], 1'b0);
      check("midreset_mosi", mosi[1], 1'b1);
      check("midreset_rsp_data", rsp_data[1], 16'h0);
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      repeat (80) begin
         @(negedge clk);
         if (rsp_valid[1]) pulses++;
      end
      check("midreset_no_rsp_valid", pulses, 0);
      do_frame(1, 4'd0, 16'h3C00, 1'b0, "after_reset");

      for (int i = 0; i < 14; i++) begin
         do_frame($urandom_range(0, 2), 4'($urandom_range(0, 15)), 16'($urandom),
                  1'($urandom_range(0, 1)), "random");
      end

      repeat (4) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
